// File: rtl/inst_mem_responder_pkg.sv
// Shared CPU definitions for the instruction-memory responder.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package inst_mem_responder_pkg;

  // Instruction returned with an error response (all-zero word).
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Responder state encoding.
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Width of a word index into a memory of 'depth' words (at least 1 bit).
  function automatic int word_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_mem_responder_imem_array.sv
// Instruction word storage: one write port, one read port.
// Latency: write lands on the clock edge; read data is combinational.
// Backpressure: none; the caller gates the write enable.
module imem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // Contents are intentionally never reset so a CPU reset keeps the program.
  logic [31:0] mem [DEPTH_WORDS];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction fetch responder: loader phase fills memory, run phase serves fetches.
// Latency: one cycle from accepted request to registered response.
// Backpressure: req_ready drops while a held response is not consumed or on flush.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        loading,
  output logic [15:0] fetch_cnt
);

  localparam int AW = word_idx_w(DEPTH_WORDS);

  logic [0:0]  state;
  logic [31:0] mem_rdata;
  logic        accept;
  logic        mem_we;

  // A byte address is usable when word aligned and inside the array.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
  endfunction

  assign loading   = (state == ST_LOAD);
  assign req_ready = (state == ST_RUN) && !flush && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  // Held off during reset so a reset cycle can never disturb the program.
  assign mem_we    = Clrn && (state == ST_LOAD) && ld_en && addr_ok(ld_addr);

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_imem (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (ld_addr[AW+1:2]),
    .wdata (ld_data),
    .raddr (req_addr[AW+1:2]),
    .rdata (mem_rdata)
  );

  // LOAD -> RUN on ld_done; only reset returns to LOAD.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state <= ST_LOAD;
    end else if ((state == ST_LOAD) && ld_done) begin
      state <= ST_RUN;
    end
  end

  // Response register: flush wins, then a new fetch, then drain on consume.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= 32'd0;
      rsp_addr  <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= req_addr;
      rsp_err   <= !addr_ok(req_addr);
      rsp_inst  <= addr_ok(req_addr) ? mem_rdata : NOP_WORD;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Accepted-fetch counter, wraps naturally at 16 bits.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      fetch_cnt <= 16'd0;
    end else if (accept) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomised bench for inst_mem_responder against a behavioural model.
// Latency: model mirrors the one-cycle fetch response.
// Backpressure: rsp_ready and flush are randomised in the random phase.
module tb_inst_mem_responder;

  localparam int DEPTH = 256;

  logic        Clk = 1'b0;
  logic        Clrn, req_valid, rsp_ready, flush, ld_en, ld_done;
  logic [31:0] req_addr, ld_addr, ld_data;
  logic        req_ready, rsp_valid, rsp_err, loading;
  logic [31:0] rsp_inst, rsp_addr;
  logic [15:0] fetch_cnt;

  always #5 Clk = ~Clk;

  inst_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .NOP_WORD    (32'h0000_0000)
  ) dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_done   (ld_done),
    .loading   (loading),
    .fetch_cnt (fetch_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model
  logic [31:0] m_mem [DEPTH];
  bit          m_run, m_vld, m_err;
  logic [31:0] m_inst, m_addr;
  logic [15:0] m_cnt;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * DEPTH);
  endfunction

  function automatic bit exp_ready();
    return m_run && !flush && (!m_vld || rsp_ready);
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit rdy;
    @(posedge Clk);
    if (!Clrn) begin
      m_run = 0; m_vld = 0; m_err = 0; m_inst = 0; m_addr = 0; m_cnt = 0;
    end else begin
      rdy = exp_ready();
      if (!m_run && ld_en && !bad_addr(ld_addr)) m_mem[ld_addr / 4] = ld_data;
      if (flush) m_vld = 0;
      else if (req_valid && rdy) begin
        m_vld  = 1;
        m_addr = req_addr;
        m_err  = bad_addr(req_addr);
        m_inst = m_err ? 32'h0 : m_mem[req_addr / 4];
        m_cnt  = m_cnt + 16'd1;
      end else if (rsp_ready) m_vld = 0;
      if (!m_run && ld_done) m_run = 1;
    end
    #1;
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("loading",   32'(loading),   32'(!m_run));
      check("req_ready", 32'(req_ready), 32'(exp_ready()));
      check("rsp_valid", 32'(rsp_valid), 32'(m_vld));
      check("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
      if (m_vld) begin
        check("rsp_inst", rsp_inst, m_inst);
        check("rsp_addr", rsp_addr, m_addr);
        check("rsp_err",  32'(rsp_err), 32'(m_err));
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic [31:0] insts [3];
    Clrn = 0; req_valid = 0; rsp_ready = 0; flush = 0; ld_en = 0; ld_done = 0;
    req_addr = 0; ld_addr = 0; ld_data = 0;
    tick(); tick();
    chk_en = 1'b1;
    // Reset state
    check("rst_loading",   32'(loading),   32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rst_rsp_inst",  rsp_inst,       32'd0);
    check("rst_rsp_addr",  rsp_addr,       32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    Clrn = 1;

    // Load every word, with ignored junk writes interleaved; last write shares ld_done.
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 8 == 3) begin
        ld_en   = 1;
        ld_addr = (i % 16 == 3) ? (32'h400 + 32'(i) * 4) : (32'(i) * 4 + 32'd1);
        ld_data = $urandom;
        tick();
      end
      ld_en   = 1;
      ld_addr = 32'(i) * 4;
      ld_data = (i == 0) ? 32'h2008_0005 : (i == 1) ? 32'h2009_000A : $urandom;
      ld_done = (i == DEPTH - 1);
      tick();
    end
    ld_done = 0;
    check("run_after_done", 32'(loading), 32'd0);
    // Writes in RUN must be ignored.
    ld_addr = 0; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 0;

    // Back-to-back fetches 0x0, 0x4, 0x0
    rsp_ready = 1;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h0;
    insts[0] = 32'h2008_0005; insts[1] = 32'h2009_000A; insts[2] = 32'h2008_0005;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = addrs[i];
      #1 check("b2b_req_ready", 32'(req_ready), 32'd1);
      tick();
      check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      check("b2b_rsp_inst",  rsp_inst,       insts[i]);
    end
    check("b2b_fetch_cnt", 32'(fetch_cnt), 32'd3);
    req_valid = 0;
    tick();
    check("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    // Single fetch of 0x4
    fetch(32'h4);
    check("f4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("f4_rsp_inst",  rsp_inst,       32'h2009_000A);
    check("f4_rsp_addr",  rsp_addr,       32'h4);
    check("f4_rsp_err",   32'(rsp_err),   32'd0);

    // Stall three cycles with a request waiting
    rsp_ready = 0; req_valid = 1; req_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_req_ready", 32'(req_ready), 32'd0);
      tick();
      check("stall_rsp_inst",  rsp_inst,       32'h2009_000A);
      check("stall_fetch_cnt", 32'(fetch_cnt), 32'd4);
    end
    rsp_ready = 1; req_valid = 0;
    tick();

    // Error responses: misaligned and out of range
    fetch(32'h2);
    check("err2_rsp_err",  32'(rsp_err), 32'd1);
    check("err2_rsp_inst", rsp_inst,     32'h0);
    fetch(32'h400);
    check("err400_rsp_err",  32'(rsp_err), 32'd1);
    check("err400_rsp_inst", rsp_inst,     32'h0);
    check("err400_rsp_addr", rsp_addr,     32'h400);
    req_valid = 0;
    tick();

    // Flush while a response is held
    fetch(32'h4);
    rsp_ready = 0; req_valid = 1; req_addr = 32'h0; flush = 1;
    #1 check("flush_req_ready", 32'(req_ready), 32'd0);
    tick();
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    flush = 0; req_valid = 0;

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      req_valid = ($urandom_range(0, 3) != 0);
      if (r == 0)      req_addr = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
      else if (r == 1) req_addr = 32'h400 + ($urandom & 32'h0000_FFFC);
      else             req_addr = $urandom_range(0, DEPTH - 1) * 4;
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      ld_en     = ($urandom_range(0, 7) == 0);
      ld_addr   = $urandom_range(0, DEPTH - 1) * 4;
      ld_data   = $urandom;
      ld_done   = ($urandom_range(0, 31) == 0);
      tick();
    end
    req_valid = 0; flush = 0; ld_en = 0; ld_done = 0; rsp_ready = 1;
    tick();

    // Reset mid-response keeps memory
    fetch(32'h4);
    Clrn = 0; req_valid = 0; rsp_ready = 0;
    tick();
    check("mrst_loading",   32'(loading),   32'd1);
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mrst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    Clrn = 1; ld_done = 1;
    tick();
    ld_done = 0; rsp_ready = 1;
    fetch(32'h0);
    check("mrst_rsp_inst", rsp_inst, 32'h2008_0005);
    req_valid = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
